// File: rtl/bucket_streamer.sv
// bucket_streamer: buffers a classified byte frame in four per-class buckets,
// then streams them out in class order (0..3) with a marked final byte.
`default_nettype none

module bucket_streamer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_class,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_class,
  output logic              out_last,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [4][DEPTH];
  // During a drain, count holds the items not yet moved into the output register.
  logic [CW-1:0]     count [4];
  logic [AW-1:0]     rptr [4];

  logic [1:0] sel;
  logic       any_left;
  logic       higher_left;
  logic       sel_last;
  logic       in_fire;
  logic       out_fire;
  logic       wr_en;
  logic       load_item;
  logic       clear_all;

  assign in_ready  = (state == FILL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_en     = in_fire && (count[in_class] != FULL);
  assign load_item = ((state == LOAD) && any_left) ||
                     ((state == DRAIN) && out_fire && !out_last);
  assign clear_all = ((state == LOAD) && !any_left) ||
                     ((state == DRAIN) && out_fire && out_last);

  // Lowest non-empty class, and whether its next item is the frame's last.
  always_comb begin
    sel         = 2'd0;
    any_left    = 1'b0;
    higher_left = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (count[i] != '0) begin
        sel      = 2'(i);
        any_left = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) > sel) && (count[i] != '0)) begin
        higher_left = 1'b1;
      end
    end
    sel_last = (count[sel] == CW'(1)) && !higher_left;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[in_class][count[in_class][AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (in_fire && in_last) state_nxt = LOAD;
      LOAD:    state_nxt = any_left ? DRAIN : FILL;
      DRAIN:   if (out_fire && out_last) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        count[i] <= '0;
        rptr[i]  <= '0;
      end
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_class <= 2'd0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_fire) begin
        if (wr_en) begin
          count[in_class] <= count[in_class] + CW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (load_item) begin
        out_data   <= mem[sel][rptr[sel]];
        out_class  <= sel;
        out_last   <= sel_last;
        out_valid  <= 1'b1;
        count[sel] <= count[sel] - CW'(1);
        rptr[sel]  <= rptr[sel] + AW'(1);
      end
      if (clear_all) begin
        for (int i = 0; i < 4; i++) begin
          count[i] <= '0;
          rptr[i]  <= '0;
        end
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bucket_streamer.sv
// Self-checking bench for bucket_streamer: queue-based frame model plus directed scenarios.
`default_nettype none

module tb_bucket_streamer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_class;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_class;
  logic              out_last;
  logic              done;
  logic              overflow;

  bucket_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_class(in_class), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_class(out_class), .out_last(out_last),
    .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] cls;
    logic       last;
  } item_t;

  int    checks = 0;
  int    errors = 0;
  item_t pend_q[$];
  item_t exp_q[$];
  int    cnt[4];
  bit    done_pend = 1'b0;
  bit    ovf_exp   = 1'b0;
  bit    bp_mode   = 1'b0;
  int    bp_k      = 0;
  logic [7:0] got_d[$];
  logic [1:0] got_c[$];
  logic       got_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: keep up to DEPTH per class, emit classes 0..3 in arrival order.
  task automatic send_byte(input logic [7:0] d, input logic [1:0] c, input logic last);
    item_t it;
    bit kept;
    in_valid = 1'b1;
    in_data  = d;
    in_class = c;
    in_last  = last;
    kept = (cnt[c] < DEPTH);
    chk("in_ready_fill", in_ready, 1);
    @(posedge clk);
    #1;
    if (kept) begin
      it = '{data: d, cls: c, last: 1'b0};
      pend_q.push_back(it);
      cnt[c]++;
    end else begin
      ovf_exp = 1'b1;
    end
    if (last) begin
      for (int k = 0; k < 4; k++)
        foreach (pend_q[j])
          if (pend_q[j].cls == 2'(k)) exp_q.push_back(pend_q[j]);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_back();
        it.last = 1'b1;
        exp_q.push_back(it);
      end
      pend_q.delete();
      for (int k = 0; k < 4; k++) cnt[k] = 0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame1();
    send_byte(8'd5, 2'd3, 1'b0);
    send_byte(8'd4, 2'd1, 1'b0);
    send_byte(8'd2, 2'd1, 1'b0);
    send_byte(8'd1, 2'd3, 1'b0);
    send_byte(8'd10, 2'd1, 1'b0);
    send_byte(8'd0, 2'd0, 1'b0);
    send_byte(8'd12, 2'd0, 1'b0);
    send_byte(8'd3, 2'd2, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  // Checks latency and back-to-back transfers right after a frame's in_last edge.
  task automatic check_stream_timing(input int n);
    int run;
    @(negedge clk);
    chk("load_cycle_valid", out_valid, 0);
    chk("load_cycle_in_ready", in_ready, 0);
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    run = 0;
    for (int i = 0; i < 40; i++) begin
      if (!out_valid) break;
      run++;
      @(negedge clk);
    end
    chk("consecutive_run", run, n);
    chk("done_after_last", done, 1);
    chk("in_ready_done_cycle", in_ready, 1);
  endtask

  // Output compare: every cycle out of reset, check done, overflow and the head item.
  always @(negedge clk) begin
    if (!reset) begin
      chk("done", done, done_pend);
      done_pend = 1'b0;
      chk("overflow", overflow, ovf_exp);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", out_valid, 0);
        end else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_class", out_class, exp_q[0].cls);
          chk("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            got_d.push_back(out_data);
            got_c.push_back(out_class);
            got_l.push_back(out_last);
            if (exp_q[0].last) done_pend = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        out_ready = ((bp_k % 4) == 0) || ((bp_k % 4) == 3);
        bp_k++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] e_data[8];
    logic [1:0] e_cls[8];
    logic [7:0] e3[3];
    e_data = '{8'd0, 8'd12, 8'd4, 8'd2, 8'd10, 8'd3, 8'd5, 8'd1};
    e_cls  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    e3     = '{8'd7, 8'd11, 8'd13};
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_class = 2'd0;
    in_last  = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Sorter frame, out_ready held high
    send_frame1();
    check_stream_timing(8);
    chk("s1_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      chk("s1_order", got_d[i], e_data[i]);
      chk("s1_class", got_c[i], e_cls[i]);
      chk("s1_last", got_l[i], (i == 7) ? 1 : 0);
    end
    got_d.delete(); got_c.delete(); got_l.delete();

    // Back-pressure with input held valid during the drain
    @(posedge clk);
    #1;
    send_frame1();
    bp_k    = 0;
    bp_mode = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_class = 2'd0;
    in_last  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("blocked_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_done();
    bp_mode = 1'b0;
    chk("s2_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++)
      chk("s2_order", got_d[i], e_data[i]);
    got_d.delete(); got_c.delete(); got_l.delete();

    // Overflow: nine class-1 bytes into an eight-deep bucket
    @(posedge clk);
    #1;
    for (int v = 1; v <= 9; v++) send_byte(8'(v), 2'd1, (v == 9));
    wait_done();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      chk("ovf_data", got_d[i], i + 1);
      chk("ovf_last", got_l[i], (i == 7) ? 1 : 0);
    end
    got_d.delete(); got_c.delete(); got_l.delete();

    // Empty-bucket skip: only class 3 populated
    @(posedge clk);
    #1;
    send_byte(8'd7, 2'd3, 1'b0);
    send_byte(8'd11, 2'd3, 1'b0);
    send_byte(8'd13, 2'd3, 1'b1);
    check_stream_timing(3);
    chk("skip_count", got_d.size(), 3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      chk("skip_data", got_d[i], e3[i]);
      chk("skip_class", got_c[i], 3);
    end
    got_d.delete(); got_c.delete(); got_l.delete();

    // Reset after the third transfer of the sorter frame
    @(posedge clk);
    #1;
    send_frame1();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (got_d.size() >= 3) break;
    end
    chk("mid_three_transfers", got_d.size(), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_overflow", overflow, 0);
    exp_q.delete();
    pend_q.delete();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    done_pend = 1'b0;
    ovf_exp   = 1'b0;
    got_d.delete(); got_c.delete(); got_l.delete();
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_byte(8'd6, 2'd0, 1'b0);
    send_byte(8'd9, 2'd2, 1'b1);
    wait_done();
    chk("post_rst_count", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("post_rst_first", got_d[0], 6);
      chk("post_rst_second", got_d[1], 9);
      chk("post_rst_first_last", got_l[0], 0);
      chk("post_rst_second_last", got_l[1], 1);
    end
    @(negedge clk);
    chk("final_model_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/bucket_streamer.md
# bucket_streamer

Downstream stage of the odd/even sorter. It accepts a frame of classified bytes over a valid/ready stream and buffers them in four per-class buckets. When the frame ends, it streams the buckets back out in fixed class order (class 0 first), skipping empty buckets, and marks the final byte of the frame. This replaces ad-hoc inspection of the sorter's internal arrays with a clean, back-pressurable output stream.

## Interface
- DATA_W, default 8: byte width.
- DEPTH, default 8: entries per bucket; must be a power of 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input byte present.
- in_ready  output  1  block accepts input; combinational, equal to (state == FILL).
- in_data  input  DATA_W  byte.
- in_class  input  2  class code: 0 = even and divisible by 6; 1 = other even; 2 = odd and divisible by 3; 3 = other odd.
- in_last  input  1  final byte of the frame.
- out_valid  output  1  output byte present; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  byte; registered.
- out_class  output  2  bucket the byte came from; registered.
- out_last  output  1  final byte of the drained frame; registered.
- done  output  1  one-cycle pulse after the final output transfer.
- overflow  output  1  sticky flag: a byte was dropped because its bucket was full.

## Operation
- States are FILL, LOAD, DRAIN.
- **Reset** (asynchronous, any state):
  - state = FILL;
  - all bucket counts and read pointers = 0;
  - out_valid = out_last = done = overflow = 0;
  - out_data = out_class = 0.
- **FILL** (in_ready = 1).
  - On each handshake (in_valid & in_ready): if count[in_class] < DEPTH, write in_data to bucket[in_class][count] and increment the count.
  - If the bucket is already full, drop the byte and set overflow = 1.
  - in_last accepted (kept or dropped) -> LOAD.
- **LOAD**: one cycle.
  - Select the lowest class with count > 0 and load its entry 0 into the output register; out_valid = 1. Go to DRAIN.
  - If all counts are 0, pulse done, leave out_valid = 0, clear the counts, and go to FILL.
- **DRAIN**: items leave each bucket in FIFO order; buckets are visited in order 0, 1, 2, 3, and empty buckets are skipped.
  - On an output handshake (out_valid & out_ready), load the next item into the output register in the same edge. There are no bubbles, including across bucket boundaries: the next non-empty class is chosen combinationally from the counts.
  - out_last = 1 exactly on the last remaining item of the highest-numbered non-empty class.
  - Handshake on an item with out_last = 1: out_valid <= 0, out_last <= 0, done <= 1 for one cycle, counts and pointers <= 0, state <= FILL.
- Output stability: while out_valid & !out_ready, out_data, out_class, and out_last hold.
- in_ready = 0 in LOAD and DRAIN. Input is never accepted during a drain.
- overflow clears only on reset.
- Read pointers are log2(DEPTH) bits wide; counts are log2(DEPTH)+1 bits wide, so a full bucket is count == DEPTH.

## Timing
- Latency: in_last handshake at edge N -> LOAD during cycle N..N+1 -> out_valid = 1 after edge N+1.
- With out_ready held at 1, K buffered bytes transfer on K consecutive edges: N+2 .. N+K+1.
- done is high for exactly the cycle after the final transfer. In that same cycle in_ready = 1, so the next frame's first byte can be accepted in the done cycle.
- Empty-frame case (every byte dropped): done is high in the cycle after the LOAD edge, and no output is produced.
- Reset mid-drain: out_valid falls asynchronously, the pending item is discarded, and no done pulse is produced.

## Test plan
- Sorter data frame 5/3, 4/1, 2/1, 1/3, 10/1, 0/0, 12/0, 3/2 (value/class), with in_last on the 3, and out_ready = 1:
  - output order 0, 12, 4, 2, 10, 3, 5, 1;
  - classes 0, 0, 1, 1, 1, 2, 3, 3;
  - out_last only on the 1;
  - 8 consecutive transfers starting 2 cycles after the in_last edge; done high the following cycle.
- Back-pressure: same frame, with out_ready toggling 1, 0, 0, 1 and so on. Order is unchanged, and out_data holds during every stall.
- Overflow: 9 bytes 1..9, all class 1 (DEPTH = 8), in_last on the 9:
  - overflow = 1;
  - outputs 1..8 only, with out_last on the 8.
- Empty-bucket skip: bytes 7, 11, 13 as class 3 only. Output is 7, 11, 13 with out_class = 3, and the first out_valid comes 2 cycles after in_last, with no extra bubbles.
- Reset mid-drain: assert reset after the 3rd transfer of the first scenario. Outputs zero immediately, in_ready = 1, and a following 2-byte frame (6/0, 9/2) yields 6 then 9 with out_last on the 9.
- Input blocking: hold in_valid = 1 during a drain. in_ready = 0, no writes occur, and the bucket contents are unchanged.
